fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL provide: rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-003 SHALL provide: stall  input  1  decode/hazard stall; hold IF/ID outputs.
REQ-004 SHALL provide: branch_taken  input  1  one-cycle redirect pulse from the branch/JAL/JR resolution logic.
REQ-005 SHALL provide: branch_target  input  16  redirect PC, valid with branch_taken.
REQ-006 SHALL provide: imem_rd_en  output  1  instruction memory read request.
REQ-007 SHALL provide: imem_addr  output  16  word address of the request.
REQ-008 SHALL provide: imem_rdy  input  1  response valid, at least 1 cycle after request acceptance.
REQ-009 SHALL provide: imem_data  input  16  instruction word, valid with imem_rdy.
REQ-010 SHALL provide: if_id_instr  output  16  instruction delivered to decode.
REQ-011 SHALL provide: if_id_pc_plus1  output  16  address of the delivered instruction plus 1.
REQ-012 SHALL provide: if_id_valid  output  1  if_id_instr holds a real instruction.
REQ-013 SHALL provide: halted  output  1  fetch stopped on HLT.

Function
REQ-014 SHALL implement states REQ, WAIT, HALT, with at most one outstanding memory read.
REQ-015 In REQ with stall=0, SHALL drive imem_rd_en=1 and imem_addr=pc, then go to WAIT at the next edge.
REQ-016 In REQ with stall=1, SHALL drive imem_rd_en=0 and stay in REQ.
REQ-017 In WAIT with imem_rdy=1 and stall=0, SHALL load if_id_instr=imem_data, if_id_pc_plus1=pc+1 and if_id_valid=1; pc SHALL become pc+1; state SHALL return to REQ.
REQ-018 In WAIT with imem_rdy=0, SHALL hold the IF/ID registers and, if stall=0, clear if_id_valid.
REQ-019 PC arithmetic SHALL be 16-bit unsigned; 0xFFFF+1 SHALL wrap to 0x0000.
REQ-020 Branch redirect, any state:
  - branch_taken=1 SHALL set pc=branch_target and clear if_id_valid at the next edge.
  - branch_taken=1 SHALL move the state to REQ.
  - branch_taken SHALL take priority over stall and over imem_rdy in the same cycle.
REQ-021 Discard on redirect: a redirect in WAIT SHALL set a drop flag, and the next imem_rdy response SHALL be discarded. No new request SHALL issue until that response returns.
REQ-022 Halt: on delivering an instruction with imem_data[15:12]=4'hF, SHALL enter HALT.
  - In HALT, halted=1 and imem_rd_en=0.
  - IF/ID SHALL keep the HLT word with if_id_valid=1 until stall=0, then if_id_valid=0.
REQ-023 A redirect in HALT SHALL exit to REQ at branch_target and clear halted, because the HLT was speculative.
REQ-024 While stall=1, if_id_instr, if_id_pc_plus1 and if_id_valid SHALL hold, unless a redirect occurs.

Reset
REQ-025 rst_n=0 SHALL asynchronously set:
  - pc=0x0000, state=REQ, drop flag=0, skid buffer empty;
  - if_id_instr=0x0000, if_id_pc_plus1=0x0000, if_id_valid=0, halted=0;
  - imem_rd_en=0 while rst_n=0.
REQ-026 SHALL issue the first request (addr 0x0000) in the first cycle after rst_n deasserts.
REQ-027 Reset during WAIT SHALL abandon the outstanding read; an imem_rdy arriving after reset release with no request issued SHALL be ignored.

Configuration
REQ-028 Macro FETCH_SKID_BUF_EN SHALL select how a response arriving in WAIT with stall=1 (no redirect) is handled.
  - Defined: the response SHALL be captured in a one-entry skid buffer, state SHALL go to REQ with no request issued, and the word SHALL be delivered from the buffer in the first cycle with stall=0, with no memory access. pc SHALL advance on delivery.
  - Undefined: the response SHALL be discarded, pc SHALL be unchanged, and the same address SHALL be re-requested once stall=0.

Verification
REQ-029 Reset release, imem returns 0x1234 at addr 0 after 1 cycle -> imem_addr=0x0000, then if_id_instr=0x1234, if_id_pc_plus1=0x0001, if_id_valid=1; next imem_addr=0x0001.
REQ-030 branch_taken=1, target=0x0040 while in WAIT for addr 0x0005 -> the 0x0005 response is dropped, if_id_valid=0, next imem_addr=0x0040.
REQ-031 Fetch of 0xF000 at addr 0x0003 -> halted=1, imem_rd_en stays 0; then branch_taken with target 0x0010 -> halted=0, imem_addr=0x0010.
REQ-032 stall=1 for 3 cycles as 0xA5A5 returns -> IF/ID held.
  - With FETCH_SKID_BUF_EN: 0xA5A5 is delivered on the cycle stall drops, with no new imem request.
  - Without it: the same address is re-requested.
REQ-033 pc=0xFFFF fetch -> if_id_pc_plus1=0x0000, next imem_addr=0x0000.
REQ-034 rst_n asserted mid-WAIT -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch_unit and the memory.
//
// Signals:
//   rd_en  fetch -> mem   read request (accepted on the clock edge it is sampled high)
//   addr   fetch -> mem   16-bit word address, meaningful while rd_en=1
//   rdy    mem -> fetch   response valid, at least one cycle after acceptance
//   data   mem -> fetch   16-bit instruction word, valid with rdy
//
// Modports: master (fetch side), slave (memory side).
interface fetch_unit_if;
   logic        rd_en;
   logic [15:0] addr;
   logic        rdy;
   logic [15:0] data;

   modport master (output rd_en, output addr, input rdy, input data);
   modport slave  (input rd_en, input addr, output rdy, output data);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one read at a time to instruction memory and
// fills the IF/ID pipeline register. Handles stalls, branch redirects (dropping
// the in-flight response), HLT detection and 16-bit PC wrap.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   stall              hold IF/ID outputs
//   branch_taken       one-cycle redirect pulse; branch_target is the new PC
//   imem               fetch_unit_if master (rd_en/addr out, rdy/data in)
//   if_id_instr        instruction delivered to decode
//   if_id_pc_plus1     address of the delivered instruction plus 1
//   if_id_valid        if_id_instr holds a real instruction
//   halted             fetch stopped on HLT (opcode 4'hF)
//
// Build option: define FETCH_SKID_BUF_EN to keep a response that arrives while
// stalled in a one-entry skid buffer instead of discarding and re-requesting it.
module fetch_unit (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [15:0]         branch_target,
   fetch_unit_if.master        imem,
   output logic [15:0]         if_id_instr,
   output logic [15:0]         if_id_pc_plus1,
   output logic                if_id_valid,
   output logic                halted
);

   localparam logic [1:0] StReq  = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StHalt = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic        drop_q, drop_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] pc_plus1_q, pc_plus1_d;
   logic        valid_q, valid_d;
   logic        skid_full;
   logic        deliver;
   logic [15:0] deliver_word;
   logic        issue;

`ifdef FETCH_SKID_BUF_EN
   logic        skid_valid_q, skid_valid_d;
   logic [15:0] skid_data_q, skid_data_d;
   assign skid_full = skid_valid_q;
`else
   assign skid_full = 1'b0;
`endif

   // No request while a dropped response is still in flight or a buffered word
   // is waiting; a redirect this cycle would orphan the request.
   assign issue = rst_n & (state_q == StReq) & ~stall & ~branch_taken & ~drop_q & ~skid_full;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drop_d       = drop_q;
      instr_d      = instr_q;
      pc_plus1_d   = pc_plus1_q;
      valid_d      = valid_q;
      deliver      = 1'b0;
      deliver_word = imem.data;
`ifdef FETCH_SKID_BUF_EN
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
`endif

      if (branch_taken) begin
         pc_d    = branch_target;
         valid_d = 1'b0;
         state_d = StReq;
         // If the outstanding response returns in this very cycle it is simply
         // ignored here; otherwise remember to discard it when it shows up.
         drop_d  = ~imem.rdy & ((state_q == StWait) | drop_q);
`ifdef FETCH_SKID_BUF_EN
         skid_valid_d = 1'b0;
`endif
      end else begin
         case (state_q)
            StReq: begin
               if (drop_q) begin
                  if (imem.rdy) drop_d = 1'b0;
                  if (!stall) valid_d = 1'b0;
               end else if (skid_full) begin
                  if (!stall) begin
                     deliver = 1'b1;
`ifdef FETCH_SKID_BUF_EN
                     deliver_word = skid_data_q;
                     skid_valid_d = 1'b0;
`endif
                  end
               end else if (!stall) begin
                  state_d = StWait;
                  valid_d = 1'b0;
               end
            end
            StWait: begin
               if (imem.rdy) begin
                  if (!stall) begin
                     deliver = 1'b1;
                  end else begin
                     // Response under stall: buffered, or discarded so the
                     // same pc is fetched again.
                     state_d = StReq;
`ifdef FETCH_SKID_BUF_EN
                     skid_valid_d = 1'b1;
                     skid_data_d  = imem.data;
`endif
                  end
               end else if (!stall) begin
                  valid_d = 1'b0;
               end
            end
            StHalt: begin
               if (!stall) valid_d = 1'b0;
            end
            default: state_d = StReq;
         endcase

         if (deliver) begin
            instr_d    = deliver_word;
            pc_plus1_d = pc_q + 16'd1;
            pc_d       = pc_q + 16'd1;
            valid_d    = 1'b1;
            state_d    = (deliver_word[15:12] == 4'hF) ? StHalt : StReq;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StReq;
         pc_q       <= 16'h0000;
         drop_q     <= 1'b0;
         instr_q    <= 16'h0000;
         pc_plus1_q <= 16'h0000;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         instr_q    <= instr_d;
         pc_plus1_q <= pc_plus1_d;
         valid_q    <= valid_d;
      end
   end

`ifdef FETCH_SKID_BUF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_valid_q <= 1'b0;
         skid_data_q  <= 16'h0000;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end
`endif

   assign imem.rd_en     = issue;
   assign imem.addr      = pc_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc_plus1 = pc_plus1_q;
   assign if_id_valid    = valid_q;
   assign halted         = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/redirect traffic,
// every cycle compared against a transaction-level reference model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc_plus1;
   logic        if_id_valid;
   logic        halted;

   fetch_unit_if imem ();

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .imem           (imem),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus1 (if_id_pc_plus1),
      .if_id_valid    (if_id_valid),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Memory responder
   logic [15:0] mem [logic [15:0]];
   int          mem_cnt = 0;
   logic [15:0] mem_addr = 16'h0000;
   int          lat_fixed = 1;
   bit          stale_pulse = 1'b0;

   // Reference model: in-flight read tracking plus architectural IF/ID view
   logic [15:0] m_pc, m_instr, m_ppc, m_held_word;
   bit          m_valid, m_stop, m_inflight, m_stale, m_held;

   bit          seen_rd;
   logic [15:0] seen_addr;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] word_at(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   task automatic model_reset();
      m_pc = 16'h0000; m_instr = 16'h0000; m_ppc = 16'h0000; m_held_word = 16'h0000;
      m_valid = 0; m_stop = 0; m_inflight = 0; m_stale = 0; m_held = 0;
   endtask

   function automatic bit model_rd(input bit s, input bit b);
      return !m_stop && !m_inflight && !m_held && !s && !b;
   endfunction

   task automatic model_deliver(input logic [15:0] w);
      m_instr = w;
      m_ppc   = m_pc + 16'd1;
      m_pc    = m_pc + 16'd1;
      m_valid = 1;
      if (w[15:12] == 4'hF) m_stop = 1;
   endtask

   task automatic model_edge(input bit s, input bit b, input logic [15:0] t,
                             input bit r, input logic [15:0] d, input bit rd);
      bit resp, fresh;
      resp  = r && m_inflight;
      fresh = resp && !m_stale;
      if (resp) begin
         m_inflight = 0;
         m_stale    = 0;
      end
      if (rd) m_inflight = 1;
      if (b) begin
         m_pc = t; m_valid = 0; m_stop = 0; m_held = 0;
         if (m_inflight) m_stale = 1;
      end else if (fresh && !s) begin
         model_deliver(d);
      end else if (fresh) begin
`ifdef FETCH_SKID_BUF_EN
         m_held      = 1;
         m_held_word = d;
`endif
      end else if (m_held && !s) begin
         model_deliver(m_held_word);
         m_held = 0;
      end else if (!s) begin
         m_valid = 0;
      end
   endtask

   // One clock cycle: drive at negedge, check 1 time unit later, update at posedge.
   task automatic step(input bit s, input bit b, input logic [15:0] t);
      bit          r, exp_rd;
      logic [15:0] d;
      @(negedge clk);
      stall = s; branch_taken = b; branch_target = t;
      r = stale_pulse || (mem_cnt == 1);
      if (stale_pulse) d = 16'hDEAD;
      else if (mem_cnt == 1) d = word_at(mem_addr);
      else d = 16'($urandom);
      stale_pulse = 1'b0;
      imem.rdy = r; imem.data = d;
      #1;
      exp_rd = model_rd(s, b);
      check_eq("rd_en", 32'(imem.rd_en), 32'(exp_rd));
      if (exp_rd) check_eq("addr", 32'(imem.addr), 32'(m_pc));
      check_eq("instr", 32'(if_id_instr), 32'(m_instr));
      check_eq("pc_plus1", 32'(if_id_pc_plus1), 32'(m_ppc));
      check_eq("valid", 32'(if_id_valid), 32'(m_valid));
      check_eq("halted", 32'(halted), 32'(m_stop));
      seen_rd = imem.rd_en; seen_addr = imem.addr;
      @(posedge clk);
      model_edge(s, b, t, r, d, exp_rd);
      if (mem_cnt > 0) mem_cnt--;
      if (seen_rd) begin
         mem_cnt  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
         mem_addr = seen_addr;
      end
   endtask

   // Let any outstanding read drain without starting a new one.
   task automatic quiesce();
      repeat (4) step(1'b1, 1'b0, 16'h0000);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_rd_en"}, 32'(imem.rd_en), 32'd0);
      check_eq({tag, "_addr"}, 32'(imem.addr), 32'h0000);
      check_eq({tag, "_instr"}, 32'(if_id_instr), 32'h0000);
      check_eq({tag, "_ppc"}, 32'(if_id_pc_plus1), 32'h0000);
      check_eq({tag, "_valid"}, 32'(if_id_valid), 32'd0);
      check_eq({tag, "_halted"}, 32'(halted), 32'd0);
   endtask

   initial begin
      bit          s, b;
      logic [15:0] t;

      rst_n = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
      imem.rdy = 1'b0; imem.data = 16'h0000;
      model_reset();
      #1 rst_n = 1'b0;
      #2 check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      check_reset_outputs("reset_hold");

      // Reset release and first fetch
      mem[16'h0000] = 16'h1234;
      mem[16'h0001] = 16'h2222;
      lat_fixed = 1;
      @(posedge clk);
      #2 rst_n = 1'b1;
      step(1'b0, 1'b0, 16'h0000);
      check_eq("first_req_rd", 32'(seen_rd), 32'd1);
      check_eq("first_req_addr", 32'(seen_addr), 32'h0000);
      step(1'b0, 1'b0, 16'h0000);
      #1;
      check_eq("first_instr", 32'(if_id_instr), 32'h1234);
      check_eq("first_ppc", 32'(if_id_pc_plus1), 32'h0001);
      check_eq("first_valid", 32'(if_id_valid), 32'd1);
      step(1'b0, 1'b0, 16'h0000);
      check_eq("second_addr", 32'(seen_addr), 32'h0001);

      // Redirect while waiting for 0x0005: its response is dropped
      quiesce();
      lat_fixed = 3;
      step(1'b0, 1'b1, 16'h0005);
      step(1'b0, 1'b0, 16'h0000);
      check_eq("drop_req_addr", 32'(seen_addr), 32'h0005);
      step(1'b0, 1'b1, 16'h0040);
      #1 check_eq("drop_valid", 32'(if_id_valid), 32'd0);
      step(1'b0, 1'b0, 16'h0000);
      check_eq("drop_wait_rd0", 32'(seen_rd), 32'd0);
      step(1'b0, 1'b0, 16'h0000);
      check_eq("drop_wait_rd1", 32'(seen_rd), 32'd0);
      step(1'b0, 1'b0, 16'h0000);
      check_eq("redirect_rd", 32'(seen_rd), 32'd1);
      check_eq("redirect_addr", 32'(seen_addr), 32'h0040);

      // HLT at 0x0003, then exit by redirect
      quiesce();
      lat_fixed = 1;
      mem[16'h0003] = 16'hF000;
      step(1'b0, 1'b1, 16'h0003);
      step(1'b0, 1'b0, 16'h0000);
      step(1'b0, 1'b0, 16'h0000);
      #1;
      check_eq("hlt_halted", 32'(halted), 32'd1);
      check_eq("hlt_instr", 32'(if_id_instr), 32'hF000);
      step(1'b1, 1'b0, 16'h0000);
      #1 check_eq("hlt_stall_valid", 32'(if_id_valid), 32'd1);
      step(1'b0, 1'b0, 16'h0000);
      #1 check_eq("hlt_release_valid", 32'(if_id_valid), 32'd0);
      step(1'b0, 1'b0, 16'h0000);
      check_eq("hlt_no_rd", 32'(seen_rd), 32'd0);
      step(1'b0, 1'b1, 16'h0010);
      #1 check_eq("hlt_exit_halted", 32'(halted), 32'd0);
      step(1'b0, 1'b0, 16'h0000);
      check_eq("hlt_exit_rd", 32'(seen_rd), 32'd1);
      check_eq("hlt_exit_addr", 32'(seen_addr), 32'h0010);

      // 0xA5A5 returns during a 3-cycle stall
      quiesce();
      lat_fixed = 2;
      mem[16'h0020] = 16'hA5A5;
      step(1'b0, 1'b1, 16'h0020);
      step(1'b0, 1'b0, 16'h0000);
      repeat (3) step(1'b1, 1'b0, 16'h0000);
      #1 check_eq("stall_hold_valid", 32'(if_id_valid), 32'd0);
      step(1'b0, 1'b0, 16'h0000);
`ifdef FETCH_SKID_BUF_EN
      check_eq("skid_no_rd", 32'(seen_rd), 32'd0);
      #1;
      check_eq("skid_instr", 32'(if_id_instr), 32'hA5A5);
      check_eq("skid_ppc", 32'(if_id_pc_plus1), 32'h0021);
      check_eq("skid_valid", 32'(if_id_valid), 32'd1);
`else
      check_eq("rereq_rd", 32'(seen_rd), 32'd1);
      check_eq("rereq_addr", 32'(seen_addr), 32'h0020);
`endif

      // PC wrap at 0xFFFF
      quiesce();
      lat_fixed = 1;
      mem[16'hFFFF] = 16'h1111;
      step(1'b0, 1'b1, 16'hFFFF);
      step(1'b0, 1'b0, 16'h0000);
      step(1'b0, 1'b0, 16'h0000);
      #1;
      check_eq("wrap_ppc", 32'(if_id_pc_plus1), 32'h0000);
      check_eq("wrap_instr", 32'(if_id_instr), 32'h1111);
      step(1'b0, 1'b0, 16'h0000);
      check_eq("wrap_next_addr", 32'(seen_addr), 32'h0000);
      check_eq("wrap_next_rd", 32'(seen_rd), 32'd1);

      // Asynchronous reset in the middle of WAIT, stale rdy after release
      quiesce();
      lat_fixed = 3;
      step(1'b0, 1'b1, 16'h0030);
      step(1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      stall = 1'b0; branch_taken = 1'b0; imem.rdy = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      model_reset();
      mem_cnt = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      stale_pulse = 1'b1;
      lat_fixed = 1;
      step(1'b0, 1'b0, 16'h0000);
      check_eq("post_rst_rd", 32'(seen_rd), 32'd1);
      check_eq("post_rst_addr", 32'(seen_addr), 32'h0000);
      step(1'b0, 1'b0, 16'h0000);
      #1 check_eq("post_rst_instr", 32'(if_id_instr), 32'h1234);

      // Randomized traffic
      mem.delete();
      lat_fixed = 0;
      for (int i = 0; i < 3000; i++) begin
         s = ($urandom_range(0, 3) == 0);
         b = m_stop ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 7) == 0) t = 16'hFFFC | 16'($urandom_range(0, 3));
         else t = 16'($urandom);
         step(s, b, t);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
